// File: rtl/nine_segment_pattern_player.sv
// Purpose : frame memory of 9-bit segment patterns played in sequence, each frame for a
//           programmable dwell, with optional looping; feeds the 3x3 row/column scan stage.
// Latency : start at edge t -> frame 0 on segments_o from cycle t+1; done_o pulses at t+1+len*dwell.
// Backpr. : none; pause_i freezes the frame index and dwell counter, stop_i aborts to IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en_i/addr_i/data_i  frame memory write port (out-of-range addresses are dropped)
//   length_i, dwell_i,     run parameters, sampled when a start is accepted
//   loop_i
//   start_i, stop_i        single-cycle control pulses (stop wins)
//   pause_i                level; freezes playback while high
//   segments_o             registered pattern to the scan stage
//   frame_idx_o, busy_o,   current frame, PLAY indicator, end-of-run pulse
//   done_o
module nine_segment_pattern_player #(
   parameter int DEPTH   = 8,
   parameter int AW      = $clog2(DEPTH),
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [8:0]         wr_data_i,
   input  logic [AW:0]        length_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic               loop_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               pause_i,
   output logic [8:0]         segments_o,
   output logic [AW-1:0]      frame_idx_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam logic [0:0]  ST_IDLE = 1'b0;
   localparam logic [0:0]  ST_PLAY = 1'b1;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [0:0]         state_q, state_d;
   logic [AW:0]        len_q, len_d;
   logic [DWELL_W-1:0] dwm1_q, dwm1_d;   // latched dwell minus one
   logic               loop_q, loop_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [8:0]         seg_q, seg_d;
   logic               done_q, done_d;
   logic [8:0]         mem_q [DEPTH];

   logic               len_ok;
   logic [DWELL_W-1:0] dwell_m1;
   logic               frame_end;
   logic               last_frame;
   logic [AW-1:0]      idx_nxt;

   assign len_ok     = (length_i != '0) && (length_i <= DEPTH_W);
   // A dwell of 0 behaves as 1, so the stored terminal count saturates at 0.
   assign dwell_m1   = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
   assign frame_end  = (cnt_q == dwm1_q);
   assign last_frame = (({1'b0, idx_q} + (AW+1)'(1)) == len_q);
   assign idx_nxt    = idx_q + AW'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      dwm1_d  = dwm1_q;
      loop_d  = loop_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      seg_d   = seg_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i && len_ok) begin
               state_d = ST_PLAY;
               len_d   = length_i;
               dwm1_d  = dwell_m1;
               loop_d  = loop_i;
               cnt_d   = '0;
               idx_d   = '0;
               seg_d   = mem_q[0];
            end
         end
         ST_PLAY: begin
            if (stop_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
               seg_d   = '0;
            end else if (!pause_i) begin
               if (frame_end) begin
                  cnt_d = '0;
                  if (last_frame) begin
                     idx_d = '0;
                     if (loop_q) begin
                        seg_d = mem_q[0];
                     end else begin
                        state_d = ST_IDLE;
                        seg_d   = '0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     // Loads read the registered memory, so a same-edge write lands afterwards.
                     idx_d = idx_nxt;
                     seg_d = mem_q[idx_nxt];
                  end
               end else begin
                  cnt_d = cnt_q + DWELL_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         dwm1_q  <= '0;
         loop_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         dwm1_q  <= dwm1_d;
         loop_q  <= loop_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         done_q  <= done_d;
         // Address decode per slot; addresses at or above DEPTH match no slot.
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_addr_i == AW'(i))) mem_q[i] <= wr_data_i;
         end
      end
   end

   assign segments_o  = seg_q;
   assign frame_idx_o = idx_q;
   assign busy_o      = (state_q == ST_PLAY);
   assign done_o      = done_q;

endmodule

// File: tb/tb_nine_segment_pattern_player.sv
module tb_nine_segment_pattern_player;

   localparam int DEPTH   = 6;
   localparam int AW      = $clog2(DEPTH);
   localparam int DWELL_W = 16;

   logic               clk;
   logic               rst_n;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [8:0]         wr_data;
   logic [AW:0]        length;
   logic [DWELL_W-1:0] dwell;
   logic               loop_en;
   logic               start;
   logic               stop;
   logic               pause;
   logic [8:0]         segments;
   logic [AW-1:0]      frame_idx;
   logic               busy;
   logic               done;

   int n_chk = 0;
   int n_err = 0;

   nine_segment_pattern_player #(.DEPTH(DEPTH), .AW(AW), .DWELL_W(DWELL_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .length_i    (length),
      .dwell_i     (dwell),
      .loop_i      (loop_en),
      .start_i     (start),
      .stop_i      (stop),
      .pause_i     (pause),
      .segments_o  (segments),
      .frame_idx_o (frame_idx),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; everything is driven and sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [8:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic start_run(input int len, input int dw, input logic lp);
      length = (AW+1)'(len); dwell = DWELL_W'(dw); loop_en = lp;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " seg"},  32'(segments), 32'h0);
      chk({tag, " busy"}, 32'(busy), 32'h0);
      chk({tag, " idx"},  32'(frame_idx), 32'h0);
   endtask

   logic [8:0] e_seg;
   logic [8:0] pat6 [0:5];
   logic [8:0] loop_seq [1:9];
   logic [AW-1:0] loop_idx [1:9];

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      length = '0; dwell = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      pat6     = '{9'h1FF, 9'h0AA, 9'h155, 9'h001, 9'h002, 9'h004};
      loop_seq = '{9'h1FF, 9'h1FF, 9'h0AA, 9'h0AA, 9'h155, 9'h155, 9'h1FF, 9'h1FF, 9'h0F0};
      loop_idx = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1};
      repeat (2) step();
      rst_n = 1'b1;

      chk_idle("reset");
      chk("reset done", 32'(done), 32'h0);
      for (int c = 0; c < 20; c++) begin
         chk_idle($sformatf("idle c%0d", c));
         step();
      end

      wr(3'd0, 9'h1FF); wr(3'd1, 9'h0AA); wr(3'd2, 9'h155);
      wr(3'd3, 9'h001); wr(3'd4, 9'h002); wr(3'd5, 9'h004);
      wr(3'd6, 9'h03C); wr(3'd7, 9'h03C);

      // Basic: len 3, dwell 4, no loop.
      start_run(3, 4, 1'b0);
      for (int c = 1; c <= 14; c++) begin
         e_seg = (c <= 4) ? 9'h1FF : (c <= 8) ? 9'h0AA : (c <= 12) ? 9'h155 : 9'h000;
         chk($sformatf("basic seg c%0d", c),  32'(segments), 32'(e_seg));
         chk($sformatf("basic done c%0d", c), 32'(done), 32'(c == 13));
         chk($sformatf("basic busy c%0d", c), 32'(busy), 32'(c <= 12));
         chk($sformatf("basic idx c%0d", c),  32'(frame_idx),
             32'((c <= 4) ? 0 : (c <= 8) ? 1 : (c <= 12) ? 2 : 0));
         step();
      end

      // Loop, dwell 2: same-edge write/load of slot 1 at c2, ignored restart at c5.
      start_run(3, 2, 1'b1);
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("loop seg c%0d", c),  32'(segments), 32'(loop_seq[c]));
         chk($sformatf("loop idx c%0d", c),  32'(frame_idx), 32'(loop_idx[c]));
         chk($sformatf("loop done c%0d", c), 32'(done), 32'h0);
         chk($sformatf("loop busy c%0d", c), 32'(busy), 32'h1);
         if (c == 2) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 9'h0F0; end
         if (c == 3) wr_en = 1'b0;
         if (c == 5) begin start = 1'b1; length = 4'd1; dwell = 16'd7; end
         if (c == 6) start = 1'b0;
         step();
      end
      // Cycle 10: stop together with pause, mid-frame.
      stop = 1'b1; pause = 1'b1;
      step();
      stop = 1'b0; pause = 1'b0;
      chk_idle("stop");
      chk("stop done", 32'(done), 32'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("stop after done c%0d", c), 32'(done), 32'h0);
         chk($sformatf("stop after busy c%0d", c), 32'(busy), 32'h0);
      end
      wr(3'd1, 9'h0AA);

      // Pause for 7 cycles inside frame 1, dwell 5.
      start_run(3, 5, 1'b0);
      for (int c = 1; c <= 24; c++) begin
         e_seg = (c <= 5) ? 9'h1FF : (c <= 17) ? 9'h0AA : (c <= 22) ? 9'h155 : 9'h000;
         chk($sformatf("pause seg c%0d", c),  32'(segments), 32'(e_seg));
         chk($sformatf("pause done c%0d", c), 32'(done), 32'(c == 23));
         if (c == 7)  pause = 1'b1;
         if (c == 14) pause = 1'b0;
         step();
      end

      // Zero and oversize lengths are rejected.
      start_run(0, 4, 1'b0);
      chk_idle("len0");
      step();
      chk_idle("len0 later");
      start_run(7, 4, 1'b0);
      chk_idle("len7");

      // Full depth, dwell 0 -> one cycle per frame; slots 0..5 untouched by writes to 6/7.
      start_run(DEPTH, 0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("full seg c%0d", c),  32'(segments), (c <= 6) ? 32'(pat6[c-1]) : 32'h0);
         chk($sformatf("full idx c%0d", c),  32'(frame_idx), (c <= 6) ? 32'(c-1) : 32'h0);
         chk($sformatf("full done c%0d", c), 32'(done), 32'(c == 7));
         step();
      end

      // Start and stop together.
      length = 4'd3; dwell = 16'd2; loop_en = 1'b0;
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk_idle("start+stop");
      step();
      chk_idle("start+stop later");

      // Asynchronous reset in the middle of a looping run.
      start_run(3, 3, 1'b1);
      repeat (4) step();
      chk("pre-reset busy", 32'(busy), 32'h1);
      chk("pre-reset seg", 32'(segments), 32'h0AA);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("async rst");
      chk("async rst done", 32'(done), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk_idle("post rst");
      start_run(3, 1, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("cleared seg c%0d", c),  32'(segments), 32'h0);
         chk($sformatf("cleared busy c%0d", c), 32'(busy), 32'h1);
         step();
      end
      chk("cleared done", 32'(done), 32'h1);
      step();
      for (int c = 0; c < 20; c++) begin
         chk_idle($sformatf("idle2 c%0d", c));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/nine_segment_pattern_player.md
Name: nine_segment_pattern_player

Overview:
- Upstream frame source for the 3x3 nine-segment LED path.
- Holds a small frame memory of 9-bit segment patterns and plays frames 0..length-1 in sequence, each for a programmable number of clock cycles, with optional looping.
- Its registered segments output drives the 9-bit segment input of the 3x3 row/column scan stage directly.

Parameters:
- DEPTH, 8, number of frame slots (2..16).
- AW, $clog2(DEPTH), frame address width.
- DWELL_W, 16, width of the per-frame dwell count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  frame memory write strobe.
- wr_addr  in  AW  frame slot to write.
- wr_data  in  9  segment pattern; bit 8 = top-left ... bit 0 = bottom-right.
- length  in  AW+1  number of frames to play; sampled on start.
- dwell  in  DWELL_W  cycles per frame; sampled on start.
- loop  in  1  1 = wrap to frame 0 after the last frame; sampled on start.
- start  in  1  begin playback (single-cycle pulse).
- stop  in  1  abort playback (single-cycle pulse).
- pause  in  1  level; while high, the dwell counter and frame index freeze.
- segments  out  9  current pattern, to the scan stage.
- frame_idx  out  AW  index of the frame being shown.
- busy  out  1  high in PLAY.
- done  out  1  one-cycle pulse on natural end of a non-looping run.

Behaviour:
- Interface: one clock domain, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, segments=0, frame_idx=0, busy=0, done=0, dwell counter=0, all frame slots=0.
- Frame memory writes: DEPTH x 9 registers, written at posedge when wr_en=1.
  - wr_addr >= DEPTH: write ignored.
  - Writes are allowed in any state.
  - A frame is read only when it is loaded. A write to the slot currently on display is not visible until that slot is next loaded.
  - Same-cycle write and load of the same slot: the load takes the old data.
- States: IDLE, PLAY.
- IDLE, start=1, stop=0, length in 1..DEPTH:
  - Latch len, dwell (0 is treated as 1) and loop.
  - Next cycle: state=PLAY, busy=1, frame_idx=0, segments=mem[0], counter=0.
- Start ignored (remain IDLE, no outputs change) when:
  - length=0 or length>DEPTH;
  - start arrives while in PLAY (no restart).
- PLAY, pause=0:
  - Counter increments each cycle.
  - When counter==dwell-1: counter resets to 0 and the next frame loads.
  - Each frame is therefore visible for exactly dwell cycles.
- PLAY, pause=1: counter, frame_idx and segments hold. The first cycle of pause=0 resumes counting.
- End of the last frame (frame_idx==len-1, counter==dwell-1, pause=0):
  - loop=1: frame_idx=0, segments=mem[0]. No done, no idle cycle.
  - loop=0: next cycle state=IDLE, segments=0, busy=0, done=1 for exactly one cycle.
- stop=1 in PLAY: next cycle state=IDLE, segments=0, frame_idx=0, busy=0, no done. stop in IDLE has no effect.
- start and stop asserted together: stop wins.
- pause and stop asserted together: stop wins.
- Latency from start at edge t:
  - Frame k is on segments for cycles t+1+k*dwell through t+(k+1)*dwell.
  - With loop=0, done=1 at cycle t+1+len*dwell.
- Arithmetic: counter is DWELL_W bits and never exceeds dwell-1. frame_idx wraps only through the loop rule.
- Reset mid-run: immediate return to reset values; frame memory is cleared.
- All outputs are registered; no combinational path from any input to segments.

Test Plan:
- Reset then idle: rst_n low mid-PLAY -> segments=0, busy=0, frame_idx=0 immediately. After release with no start, outputs stay 0 for 20 cycles.
- Basic play: write mem[0..2]=0x1FF,0x0AA,0x155; length=3, dwell=4, loop=0; start at t -> each pattern held 4 cycles starting t+1, segments=0 and done=1 at t+13, done low at t+14.
- Loop and stop: same frames, loop=1, dwell=2 -> sequence 1FF,1FF,0AA,0AA,155,155,1FF,... with no gap and no done. stop mid-frame -> segments=0 next cycle, done never pulses.
- Pause: dwell=5, pause high for 7 cycles during frame 1 -> frame 1 is visible for 12 cycles total, and subsequent timing shifts by 7.
- Boundaries:
  - length=0 start -> remains IDLE.
  - length=DEPTH, dwell=0 -> each frame shown 1 cycle.
  - start+stop same cycle -> IDLE.
  - start during PLAY -> ignored.
  - wr_addr>=DEPTH -> no change (non-power-of-2 DEPTH=6 build).
- Live write: write mem[1] while frame 1 is displayed -> segments unchanged until frame 1 is revisited on the next loop, where the new value appears.
